fp_mul_pipe: RTL and testbench

- Parametrised, pipelined floating-point multiplier. Successor to the fixed single-precision multiplier.
- Format widths are generic (EXP_W/MAN_W). Five rounding modes are supported.
- Adds a valid/ready handshake with backpressure, a transaction ID passthrough, and an invalid-operation flag.
- Sits between the stimulus/sequence layer and the scoreboard-checked datapath. Sustains one result per cycle.

---
 rtl/fp_mul_pipe.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-style floating-point multiplier with generic exponent/mantissa widths,
// five rounding modes, valid/ready backpressure and a transaction tag passthrough.
module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int ID_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             r_mode,
   input  logic [EXP_W+MAN_W:0]   fp_X,
   input  logic [EXP_W+MAN_W:0]   fp_Y,
   input  logic [ID_W-1:0]        in_id,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   fp_Z,
   output logic                   ovrf,
   output logic                   udrf,
   output logic                   nv,
   output logic [ID_W-1:0]        out_id
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;
   localparam int PW = 2 * SW;
   localparam int EW = EXP_W + 2;

   localparam logic [EW-1:0] BIAS_E = EW'(2 ** (EXP_W - 1) - 1);
   localparam logic [EW-1:0] OVF_E  = EW'(2 ** EXP_W - 1 + 2 ** (EXP_W - 1) - 1);

   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   // Handshake: an operation is accepted when in_valid && in_ready. A result
   // leaves when out_valid && out_ready. The whole pipe advances unless the
   // output holds a result the consumer refuses; in_ready mirrors that advance.
   logic w_advance;

   logic                r_in_valid;
   logic [W-1:0]        r_in_x;
   logic [W-1:0]        r_in_y;
   logic [2:0]          r_in_mode;
   logic [ID_W-1:0]     r_in_id;

   logic                r_s1_valid;
   logic                r_s1_sign;
   logic [2:0]          r_s1_mode;
   logic [ID_W-1:0]     r_s1_id;
   logic                r_s1_spec;
   logic [W-1:0]        r_s1_spec_z;
   logic                r_s1_spec_nv;
   logic [SW-1:0]       r_s1_mx;
   logic [SW-1:0]       r_s1_my;
   logic [EW-1:0]       r_s1_esum;

   logic                r_s2_valid;
   logic                r_s2_sign;
   logic [2:0]          r_s2_mode;
   logic [ID_W-1:0]     r_s2_id;
   logic                r_s2_spec;
   logic [W-1:0]        r_s2_spec_z;
   logic                r_s2_spec_nv;
   logic [PW-1:0]       r_s2_prod;
   logic [EW-1:0]       r_s2_esum;

   logic                r_out_valid;
   logic [W-1:0]        r_fp_Z;
   logic                r_ovrf;
   logic                r_udrf;
   logic                r_nv;
   logic [ID_W-1:0]     r_out_id;

   assign w_advance = !(r_out_valid && !out_ready);
   assign in_ready  = w_advance;
   assign out_valid = r_out_valid;
   assign fp_Z      = r_fp_Z;
   assign ovrf      = r_ovrf;
   assign udrf      = r_udrf;
   assign nv        = r_nv;
   assign out_id    = r_out_id;

   // ---------------- operand capture ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_valid <= 1'b0;
         r_in_x     <= '0;
         r_in_y     <= '0;
         r_in_mode  <= '0;
         r_in_id    <= '0;
      end else if (w_advance) begin
         r_in_valid <= in_valid;
         r_in_x     <= fp_X;
         r_in_y     <= fp_Y;
         r_in_mode  <= r_mode;
         r_in_id    <= in_id;
      end
   end

   // ---------------- S1: unpack, classify, exponent add ----------------
   logic              w_x_sign, w_y_sign, w_sign;
   logic [EXP_W-1:0]  w_x_exp, w_y_exp;
   logic [MAN_W-1:0]  w_x_man, w_y_man;
   logic              w_x_nan, w_y_nan, w_x_snan, w_y_snan;
   logic              w_x_inf, w_y_inf, w_x_zero, w_y_zero;
   logic              w_spec, w_spec_nv;
   logic [W-1:0]      w_spec_z;
   logic [2:0]        w_mode_n;
   logic [EW-1:0]     w_esum;

   assign w_x_sign = r_in_x[W-1];
   assign w_y_sign = r_in_y[W-1];
   assign w_x_exp  = r_in_x[W-2:MAN_W];
   assign w_y_exp  = r_in_y[W-2:MAN_W];
   assign w_x_man  = r_in_x[MAN_W-1:0];
   assign w_y_man  = r_in_y[MAN_W-1:0];
   assign w_sign   = w_x_sign ^ w_y_sign;

   assign w_x_nan  = (&w_x_exp) && (|w_x_man);
   assign w_y_nan  = (&w_y_exp) && (|w_y_man);
   assign w_x_snan = w_x_nan && !w_x_man[MAN_W-1];
   assign w_y_snan = w_y_nan && !w_y_man[MAN_W-1];
   assign w_x_inf  = (&w_x_exp) && !(|w_x_man);
   assign w_y_inf  = (&w_y_exp) && !(|w_y_man);
   assign w_x_zero = !(|w_x_exp);
   assign w_y_zero = !(|w_y_exp);

   assign w_mode_n = (r_in_mode > RM_RMM) ? RM_RNE : r_in_mode;
   assign w_esum   = EW'(w_x_exp) + EW'(w_y_exp);

   // Subnormal operands share the exponent-zero class and are flushed like zeros.
   always_comb begin
      w_spec    = 1'b1;
      w_spec_nv = 1'b0;
      w_spec_z  = QNAN;
      if (w_x_nan || w_y_nan) begin
         w_spec_nv = w_x_snan || w_y_snan;
      end else if ((w_x_inf && w_y_zero) || (w_y_inf && w_x_zero)) begin
         w_spec_nv = 1'b1;
      end else if (w_x_inf || w_y_inf) begin
         w_spec_z = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (w_x_zero || w_y_zero) begin
         w_spec_z = {w_sign, {(W-1){1'b0}}};
      end else begin
         w_spec = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid   <= 1'b0;
         r_s1_sign    <= 1'b0;
         r_s1_mode    <= '0;
         r_s1_id      <= '0;
         r_s1_spec    <= 1'b0;
         r_s1_spec_z  <= '0;
         r_s1_spec_nv <= 1'b0;
         r_s1_mx      <= '0;
         r_s1_my      <= '0;
         r_s1_esum    <= '0;
      end else if (w_advance) begin
         r_s1_valid   <= r_in_valid;
         r_s1_sign    <= w_sign;
         r_s1_mode    <= w_mode_n;
         r_s1_id      <= r_in_id;
         r_s1_spec    <= w_spec;
         r_s1_spec_z  <= w_spec_z;
         r_s1_spec_nv <= w_spec_nv;
         r_s1_mx      <= {1'b1, w_x_man};
         r_s1_my      <= {1'b1, w_y_man};
         r_s1_esum    <= w_esum;
      end
   end

   // ---------------- S2: significand multiply ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid   <= 1'b0;
         r_s2_sign    <= 1'b0;
         r_s2_mode    <= '0;
         r_s2_id      <= '0;
         r_s2_spec    <= 1'b0;
         r_s2_spec_z  <= '0;
         r_s2_spec_nv <= 1'b0;
         r_s2_prod    <= '0;
         r_s2_esum    <= '0;
      end else if (w_advance) begin
         r_s2_valid   <= r_s1_valid;
         r_s2_sign    <= r_s1_sign;
         r_s2_mode    <= r_s1_mode;
         r_s2_id      <= r_s1_id;
         r_s2_spec    <= r_s1_spec;
         r_s2_spec_z  <= r_s1_spec_z;
         r_s2_spec_nv <= r_s1_spec_nv;
         r_s2_prod    <= PW'(r_s1_mx) * PW'(r_s1_my);
         r_s2_esum    <= r_s1_esum;
      end
   end

   // ---------------- S3: normalise, round, pack, flags ----------------
   logic              w_norm, w_guard, w_sticky, w_up, w_to_inf;
   logic [MAN_W-1:0]  w_mant;
   logic [MAN_W:0]    w_mant_r;
   logic [EW-1:0]     w_e_pre, w_e_post;
   logic [EXP_W-1:0]  w_exp_f;
   logic              w_udf, w_ovf;
   logic [W-1:0]      w_res_z;
   logic              w_res_ovrf, w_res_udrf, w_res_nv;

   // Both significands carry a hidden one, so the product's leading one sits
   // in one of its top two bits.
   assign w_norm   = r_s2_prod[PW-1];
   assign w_mant   = w_norm ? r_s2_prod[PW-2 -: MAN_W] : r_s2_prod[PW-3 -: MAN_W];
   assign w_guard  = w_norm ? r_s2_prod[MAN_W] : r_s2_prod[MAN_W-1];
   assign w_sticky = w_norm ? (|r_s2_prod[MAN_W-1:0]) : (|r_s2_prod[MAN_W-2:0]);

   always_comb begin
      w_up = 1'b0;
      case (r_s2_mode)
         RM_RTZ:  w_up = 1'b0;
         RM_RDN:  w_up = (w_guard || w_sticky) && r_s2_sign;
         RM_RUP:  w_up = (w_guard || w_sticky) && !r_s2_sign;
         RM_RMM:  w_up = w_guard;
         default: w_up = w_guard && (w_sticky || w_mant[0]);
      endcase
   end

   // Exponents stay biased twice over (eX+eY) so every compare is unsigned.
   assign w_mant_r = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_up};
   assign w_e_pre  = r_s2_esum + {{(EW-1){1'b0}}, w_norm};
   assign w_e_post = w_e_pre + {{(EW-1){1'b0}}, w_mant_r[MAN_W]};
   assign w_exp_f  = EXP_W'(w_e_post - BIAS_E);
   assign w_udf    = (w_e_pre <= BIAS_E);
   assign w_ovf    = !w_udf && (w_e_post >= OVF_E);

   always_comb begin
      w_to_inf = 1'b1;
      case (r_s2_mode)
         RM_RTZ:  w_to_inf = 1'b0;
         RM_RUP:  w_to_inf = !r_s2_sign;
         RM_RDN:  w_to_inf = r_s2_sign;
         default: w_to_inf = 1'b1;
      endcase
   end

   always_comb begin
      w_res_z    = {r_s2_sign, w_exp_f, w_mant_r[MAN_W-1:0]};
      w_res_ovrf = 1'b0;
      w_res_udrf = 1'b0;
      w_res_nv   = 1'b0;
      if (r_s2_spec) begin
         w_res_z  = r_s2_spec_z;
         w_res_nv = r_s2_spec_nv;
      end else if (w_udf) begin
         w_res_z    = {r_s2_sign, {(W-1){1'b0}}};
         w_res_udrf = 1'b1;
      end else if (w_ovf) begin
         w_res_ovrf = 1'b1;
         if (w_to_inf)
            w_res_z = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         else
            w_res_z = {r_s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_fp_Z      <= '0;
         r_ovrf      <= 1'b0;
         r_udrf      <= 1'b0;
         r_nv        <= 1'b0;
         r_out_id    <= '0;
      end else if (w_advance) begin
         r_out_valid <= r_s2_valid;
         r_fp_Z      <= w_res_z;
         r_ovrf      <= w_res_ovrf;
         r_udrf      <= w_res_udrf;
         r_nv        <= w_res_nv;
         r_out_id    <= r_s2_id;
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (single-precision configuration): directed vectors, an
// arithmetic reference model feeding an expected queue, handshake and reset checks.
module tb_fp_mul_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  r_mode;
   logic [31:0] fp_X;
   logic [31:0] fp_Y;
   logic [3:0]  in_id;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] fp_Z;
   logic        ovrf;
   logic        udrf;
   logic        nv;
   logic [3:0]  out_id;

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .ID_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .r_mode    (r_mode),
      .fp_X      (fp_X),
      .fp_Y      (fp_Y),
      .in_id     (in_id),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fp_Z      (fp_Z),
      .ovrf      (ovrf),
      .udrf      (udrf),
      .nv        (nv),
      .out_id    (out_id)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc_cyc = 0;
   int n_seen  = 0;

   // {id, z, ovrf, udrf, nv}
   logic [38:0] exp_q[$];

   localparam int NV = 28;
   logic [31:0] vx [NV] = '{
      32'h3FC00000, 32'h7F000000, 32'h7F000000, 32'hFF000000, 32'h00800000, 32'h80800000,
      32'h00000001, 32'h7F800000, 32'h7F800001, 32'hFF800000, 32'h3F800001, 32'h3F800001,
      32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800002, 32'h3F800002, 32'h3F800001,
      32'h3FC00000, 32'h3F800003, 32'h3F800003, 32'h7F000000, 32'hFF000000, 32'h7FC00000,
      32'h3F800001, 32'hFFC00000, 32'h80000000, 32'h7F800000};
   logic [31:0] vy [NV] = '{
      32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h00800000, 32'h00800000,
      32'h3F800000, 32'h00000000, 32'h3F800000, 32'h40000000, 32'h3F800001, 32'h3F800001,
      32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3FA00000, 32'h3FA00000, 32'h3FC00000,
      32'h3FC00000, 32'h3FFFFFFA, 32'h3FFFFFFA, 32'h40000000, 32'h40000000, 32'h3F800000,
      32'h3F800001, 32'h00000000, 32'h40000000, 32'h80000000};
   logic [2:0] vm [NV] = '{
      3'd0, 3'd0, 3'd1, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
      3'd4, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0};
   logic [31:0] vz [NV] = '{
      32'h40400000, 32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00000000, 32'h80000000,
      32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h3F800002, 32'h3F800002,
      32'h3F800002, 32'h3F800003, 32'h3F800002, 32'h3FA00002, 32'h3FA00003, 32'h3FC00002,
      32'h40100000, 32'h40000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 32'hFF800000, 32'h7FC00000,
      32'h3F800002, 32'h7FC00000, 32'h80000000, 32'h7FC00000};
   // {ovrf, udrf, nv}
   logic [2:0] vf [NV] = '{
      3'b000, 3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b000, 3'b001, 3'b001, 3'b000,
      3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
      3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};

   // Reference: exact integer product, round by comparing the discarded remainder
   // against one half ulp, then apply the special-value and range rules.
   function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] m);
      int ex, ey, e, top, sh;
      logic s, xnan, ynan, up, to_inf;
      longint unsigned p, keep, rem, half;
      logic [31:0] inf_v, max_v;
      logic [2:0] rm;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      s = x[31] ^ y[31];
      inf_v = {s, 8'hFF, 23'h0};
      max_v = {s, 8'hFE, 23'h7FFFFF};
      xnan = (ex == 255) && (x[22:0] != 0);
      ynan = (ey == 255) && (y[22:0] != 0);
      if (xnan || ynan)
         return {32'h7FC00000, 2'b00, (xnan && !x[22]) || (ynan && !y[22])};
      if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0))
         return {32'h7FC00000, 3'b001};
      if (ex == 255 || ey == 255)
         return {inf_v, 3'b000};
      if (ex == 0 || ey == 0)
         return {s, 31'h0, 3'b000};
      p = (longint'(x[22:0]) + 64'd8388608) * (longint'(y[22:0]) + 64'd8388608);
      top = (p >= 64'h0000_8000_0000_0000) ? 47 : 46;
      e = ex + ey - 127 + (top - 46);
      if (e < 1)
         return {s, 31'h0, 3'b010};
      sh = top - 23;
      keep = p >> sh;
      rem = p - (keep << sh);
      half = 64'd1 << (sh - 1);
      rm = (m > 3'd4) ? 3'd0 : m;
      case (rm)
         3'd1:    up = 1'b0;
         3'd2:    up = (rem != 0) && s;
         3'd3:    up = (rem != 0) && !s;
         3'd4:    up = (rem >= half);
         default: up = (rem > half) || ((rem == half) && keep[0]);
      endcase
      keep = keep + longint'(up);
      if (keep == (64'd1 << 24)) begin
         keep = keep >> 1;
         e = e + 1;
      end
      if (e >= 255) begin
         to_inf = (rm == 3'd0) || (rm == 3'd4) || (rm == 3'd3 && !s) || (rm == 3'd2 && s);
         return {to_inf ? inf_v : max_v, 3'b100};
      end
      return {s, 8'(e), keep[22:0], 3'b000};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                       input logic [3:0] id);
      logic acc;
      int n;
      fp_X = x;
      fp_Y = y;
      r_mode = m;
      in_id = id;
      in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
      acc_cyc = cyc;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready)
         exp_q.push_back({in_id, model(fp_X, fp_Y, r_mode)});
   end

   logic        held_valid = 1'b0;
   logic [31:0] held_z;
   logic [3:0]  held_id;
   logic [2:0]  held_f;

   always @(negedge clk) begin
      logic [38:0] e;
      if (!rst_n) begin
         held_valid = 1'b0;
      end else begin
         if (held_valid) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_z", 64'(fp_Z), 64'(held_z));
            check("hold_id", 64'(out_id), 64'(held_id));
            check("hold_flags", 64'({ovrf, udrf, nv}), 64'(held_f));
         end
         held_valid = out_valid && !out_ready;
         held_z = fp_Z;
         held_id = out_id;
         held_f = {ovrf, udrf, nv};
         check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
         if (out_valid && out_ready) begin
            n_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_output", 64'(fp_Z), 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check("out_z", 64'(fp_Z), 64'(e[34:3]));
               check("out_flags", 64'({ovrf, udrf, nv}), 64'(e[2:0]));
               check("out_id", 64'(out_id), 64'(e[38:35]));
            end
         end
      end
   end

   // ---------------- sequence ----------------
   initial begin
      int n;
      int seen0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      fp_X = '0;
      fp_Y = '0;
      r_mode = '0;
      in_id = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_fp_Z", 64'(fp_Z), 64'd0);
      check("rst_flags", 64'({ovrf, udrf, nv}), 64'd0);
      check("rst_out_id", 64'(out_id), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // pin the reference model against hand-computed results
      for (int i = 0; i < NV; i++)
         check($sformatf("model_vec%0d", i), 64'(model(vx[i], vy[i], vm[i])), 64'({vz[i], vf[i]}));

      // basic product and latency
      send(32'h3FC00000, 32'h40000000, 3'd0, 4'd5);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 64'(cyc - acc_cyc), 64'd3);
      check("basic_z", 64'(fp_Z), 64'h40400000);
      check("basic_id", 64'(out_id), 64'd5);
      drain();

      // all directed vectors back to back
      for (int i = 0; i < NV; i++)
         send(vx[i], vy[i], vm[i], 4'(i));
      in_valid = 1'b0;
      drain();

      // backpressure: ids 0..7, consumer stalls 5 cycles at first result
      seen0 = n_seen;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(vx[10 + i], vy[10 + i], vm[10 + i], 4'(i));
            in_valid = 1'b0;
         end
         begin
            int k;
            k = 0;
            while (!out_valid && k < 50) begin
               @(posedge clk);
               #1;
               k++;
            end
            check("bp_first_valid", 64'(out_valid), 64'd1);
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("bp_in_ready_low", 64'(in_ready), 64'd0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", 64'(n_seen - seen0), 64'd8);

      // reset while results are in flight
      for (int i = 0; i < 3; i++)
         send(vx[i], vy[i], vm[i], 4'(8 + i));
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("mid_rst_pre_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_fp_Z", 64'(fp_Z), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen0 = n_seen;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_no_stale", 64'(n_seen - seen0), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
